// File: rtl/baseblocks_v5_0_pkg.sv
// Shared gate-type constants and elaboration-time helpers for the
// pipelined bus reduction.
package baseblocks_v5_0_pkg;

   localparam int c_and  = 0;
   localparam int c_nand = 1;
   localparam int c_or   = 2;
   localparam int c_nor  = 3;
   localparam int c_xor  = 4;
   localparam int c_xnor = 5;

   // Base operator that each stage actually evaluates
   localparam int c_op_and = 0;
   localparam int c_op_or  = 1;
   localparam int c_op_xor = 2;

   function automatic int base_op(input int gate);
      case (gate)
         c_or, c_nor:   return c_op_or;
         c_xor, c_xnor: return c_op_xor;
         default:       return c_op_and;
      endcase
   endfunction

   // Padding value that leaves the base operator's result unchanged
   function automatic logic identity_val(input int gate);
      return (gate == c_and) || (gate == c_nand);
   endfunction

   function automatic logic final_inv(input int gate);
      return (gate == c_nand) || (gate == c_nor) || (gate == c_xnor);
   endfunction

   // Smallest stage count s >= 1 with group**s >= width
   function automatic int calc_stages(input int width, input int group);
      int s;
      int span;
      s    = 1;
      span = group;
      while (span < width) begin
         span = span * group;
         s    = s + 1;
      end
      return s;
   endfunction

   // Bus width entering a given level (level 0 is the primary input)
   function automatic int stage_width(input int width, input int group, input int level);
      int w;
      w = width;
      for (int k = 0; k < level; k++) begin
         w = (w + group - 1) / group;
      end
      return w;
   endfunction

endpackage

// File: rtl/c_reduce_stage_v5_0.sv
// One registered reduction level: folds groups of GROUP bits into one bit
// each, padding the last group with the operator identity.
module c_reduce_stage_v5_0
   import baseblocks_v5_0_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int GROUP = 4,
   parameter int GATE  = 0,
   parameter bit LAST  = 1'b0,
   parameter int OUT_W = (IN_W + GROUP - 1) / GROUP
) (
   input  logic             clk,
   input  logic             aclr_n,
   input  logic             adv,
   input  logic             clr,
   input  logic [IN_W-1:0]  d,
   input  logic             d_valid,
   output logic [OUT_W-1:0] q,
   output logic             q_valid
);

   localparam int PAD_W = OUT_W * GROUP;
   localparam int OP    = base_op(GATE);
   localparam bit ID    = identity_val(GATE);
   // Only the last level applies the NAND/NOR/XNOR inversion
   localparam bit INV   = LAST && final_inv(GATE);

   logic [PAD_W-1:0] padded;
   logic [OUT_W-1:0] reduced;

   always_comb begin
      padded           = {PAD_W{ID}};
      padded[IN_W-1:0] = d;
   end

   for (genvar gi = 0; gi < OUT_W; gi++) begin : g_group
      logic [GROUP-1:0] grp;
      logic             base;

      assign grp = padded[gi*GROUP +: GROUP];

      if (OP == c_op_and) begin : g_and
         assign base = &grp;
      end else if (OP == c_op_or) begin : g_or
         assign base = |grp;
      end else begin : g_xor
         assign base = ^grp;
      end

      assign reduced[gi] = base ^ INV;
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (clr) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else if (adv) begin
         q       <= reduced;
         q_valid <= d_valid;
      end
   end

endmodule

// File: rtl/c_reduce_bus_pipe_v5_0.sv
// Pipelined wide-bus AND/NAND/OR/NOR/XOR/XNOR reduction with a valid/ready
// handshake; backpressure is a single combinational advance signal.
module c_reduce_bus_pipe_v5_0
   import baseblocks_v5_0_pkg::*;
#(
   parameter int                 C_WIDTH          = 16,
   parameter int                 C_GATE_TYPE      = 0,
   parameter logic [C_WIDTH-1:0] C_INPUT_INV_MASK = '0,
   parameter int                 C_GROUP          = 4
) (
   input  logic               CLK,
   input  logic               ACLR_N,
   input  logic               CE,
   input  logic               SCLR,
   input  logic [C_WIDTH-1:0] I,
   input  logic               I_VALID,
   output logic               I_READY,
   output logic               Q,
   output logic               O_VALID,
   input  logic               O_READY
);

   localparam int STAGES = calc_stages(C_WIDTH, C_GROUP);

   // Level k occupies chain[k*C_WIDTH +: C_WIDTH]; only its low bits are live
   logic [(STAGES+1)*C_WIDTH-1:0] chain;
   logic [STAGES:0]               vchain;
   logic                          adv;
   logic                          ce_clr;

   assign adv     = CE & (~O_VALID | O_READY);
   assign ce_clr  = CE & SCLR;
   assign I_READY = adv;

   assign chain[C_WIDTH-1:0] = I ^ C_INPUT_INV_MASK;
   assign vchain[0]          = I_VALID;

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int IN_W  = stage_width(C_WIDTH, C_GROUP, gi);
      localparam int OUT_W = stage_width(C_WIDTH, C_GROUP, gi + 1);

      c_reduce_stage_v5_0 #(
         .IN_W  (IN_W),
         .GROUP (C_GROUP),
         .GATE  (C_GATE_TYPE),
         .LAST  (gi == STAGES - 1)
      ) u_stage (
         .clk     (CLK),
         .aclr_n  (ACLR_N),
         .adv     (adv),
         .clr     (ce_clr),
         .d       (chain[gi*C_WIDTH +: IN_W]),
         .d_valid (vchain[gi]),
         .q       (chain[(gi+1)*C_WIDTH +: OUT_W]),
         .q_valid (vchain[gi+1])
      );

      if (OUT_W < C_WIDTH) begin : g_tie_hi
         assign chain[(gi+1)*C_WIDTH+OUT_W +: C_WIDTH-OUT_W] = '0;
      end

      if (IN_W < C_WIDTH) begin : g_sink_hi
         logic unused_hi;
         assign unused_hi = ^chain[gi*C_WIDTH+IN_W +: C_WIDTH-IN_W];
      end
   end

   logic unused_tail;
   assign unused_tail = ^chain[(STAGES+1)*C_WIDTH-1 : STAGES*C_WIDTH+1];

   assign Q       = chain[STAGES*C_WIDTH];
   assign O_VALID = vchain[STAGES];

endmodule

// File: tb/tb_c_reduce_bus_pipe_v5_0.sv
// Directed bench: AND/16 (2 stages), XNOR/17 (3 stages) and inverted-OR/16
// instances share stimulus; a vector table plus stall/clear/reset sequences.
module tb_c_reduce_bus_pipe_v5_0;

   logic        CLK = 1'b0;
   logic        ACLR_N;
   logic        CE;
   logic        SCLR;
   logic        I_VALID;
   logic        O_READY;
   logic [16:0] i_bus;

   logic q_and,  ov_and,  ir_and;
   logic q_xnor, ov_xnor, ir_xnor;
   logic q_or,   ov_or,   ir_or;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   c_reduce_bus_pipe_v5_0 dut_and (
      .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR),
      .I(i_bus[15:0]), .I_VALID(I_VALID), .I_READY(ir_and),
      .Q(q_and), .O_VALID(ov_and), .O_READY(O_READY)
   );

   c_reduce_bus_pipe_v5_0 #(.C_WIDTH(17), .C_GATE_TYPE(5)) dut_xnor (
      .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR),
      .I(i_bus), .I_VALID(I_VALID), .I_READY(ir_xnor),
      .Q(q_xnor), .O_VALID(ov_xnor), .O_READY(O_READY)
   );

   c_reduce_bus_pipe_v5_0 #(.C_GATE_TYPE(2), .C_INPUT_INV_MASK(16'hFFFF)) dut_or (
      .CLK(CLK), .ACLR_N(ACLR_N), .CE(CE), .SCLR(SCLR),
      .I(i_bus[15:0]), .I_VALID(I_VALID), .I_READY(ir_or),
      .Q(q_or), .O_VALID(ov_or), .O_READY(O_READY)
   );

   typedef struct {
      logic [16:0] i;
      logic        e_and;
      logic        e_xnor;
      logic        e_or;
   } vec_t;

   localparam int N = 11;
   vec_t tab [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic all_idle(input string tag);
      check({tag, "_ov_and"},  ov_and,  1'b0);
      check({tag, "_ov_xnor"}, ov_xnor, 1'b0);
      check({tag, "_ov_or"},   ov_or,   1'b0);
   endtask

   initial begin
      // expected: AND of I[15:0]; XNOR of I[16:0]; OR of ~I[15:0]
      tab[0]  = '{17'h0FFFF, 1'b1, 1'b1, 1'b0};
      tab[1]  = '{17'h0FFFE, 1'b0, 1'b0, 1'b1};
      tab[2]  = '{17'h00001, 1'b0, 1'b0, 1'b1};
      tab[3]  = '{17'h0FFF7, 1'b0, 1'b0, 1'b1};
      tab[4]  = '{17'h1FFFF, 1'b1, 1'b0, 1'b0};
      tab[5]  = '{17'h00000, 1'b0, 1'b1, 1'b1};
      tab[6]  = '{17'h10000, 1'b0, 1'b0, 1'b1};
      tab[7]  = '{17'h0A5A5, 1'b0, 1'b1, 1'b1};
      tab[8]  = '{17'h07FFF, 1'b0, 1'b0, 1'b1};
      tab[9]  = '{17'h18001, 1'b0, 1'b0, 1'b1};
      tab[10] = '{17'h1FFFE, 1'b0, 1'b1, 1'b1};

      ACLR_N  = 1'b1;
      CE      = 1'b1;
      SCLR    = 1'b0;
      I_VALID = 1'b0;
      O_READY = 1'b1;
      i_bus   = '0;

      // Reset state
      #1 ACLR_N = 1'b0;
      #10;
      all_idle("rst");
      check("rst_q_and", q_and, 1'b0);
      check("rst_q_xnor", q_xnor, 1'b0);
      check("rst_q_or", q_or, 1'b0);
      #2 ACLR_N = 1'b1;
      #1;
      check("rel_ir_and", ir_and, 1'b1);
      check("rel_ir_xnor", ir_xnor, 1'b1);
      step();

      // Back-to-back stream then bubbles: latency 2 for AND/OR, 3 for XNOR
      for (int e = 0; e < N + 3; e++) begin
         if (e < N) begin
            i_bus   = tab[e].i;
            I_VALID = 1'b1;
         end else begin
            I_VALID = 1'b0;
         end
         #1;
         check("str_ir_and", ir_and, 1'b1);
         step();
         if (e >= 1 && e - 1 < N) begin
            check("str_ov_and", ov_and, 1'b1);
            check("str_q_and", q_and, tab[e-1].e_and);
            check("str_ov_or", ov_or, 1'b1);
            check("str_q_or", q_or, tab[e-1].e_or);
         end else begin
            check("str_ov_and", ov_and, 1'b0);
            check("str_ov_or", ov_or, 1'b0);
         end
         if (e >= 2 && e - 2 < N) begin
            check("str_ov_xnor", ov_xnor, 1'b1);
            check("str_q_xnor", q_xnor, tab[e-2].e_xnor);
         end else begin
            check("str_ov_xnor", ov_xnor, 1'b0);
         end
         $display("cycle %0d: q_and=%b/%b q_xnor=%b/%b q_or=%b/%b", e,
                  ov_and, q_and, ov_xnor, q_xnor, ov_or, q_or);
      end

      // Output stall for 5 cycles, then release
      i_bus = 17'h0FFFF; I_VALID = 1'b1; step();
      i_bus = 17'h0FFFE; step();
      I_VALID = 1'b0; O_READY = 1'b0; #1;
      check("stall_pre_ov_and", ov_and, 1'b1);
      check("stall_pre_q_and", q_and, 1'b1);
      check("stall_pre_ir_and", ir_and, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         check("stall_q_and", q_and, 1'b1);
         check("stall_ov_and", ov_and, 1'b1);
         check("stall_ir_and", ir_and, 1'b0);
         check("stall_q_or", q_or, 1'b0);
         check("stall_ov_xnor", ov_xnor, 1'b1);
         check("stall_q_xnor", q_xnor, 1'b1);
         $display("stall %0d: q_and=%b ov_and=%b ir_and=%b", k, q_and, ov_and, ir_and);
      end
      O_READY = 1'b1;
      step();
      check("unstall_ov_and", ov_and, 1'b1);
      check("unstall_q_and", q_and, 1'b0);
      check("unstall_q_or", q_or, 1'b1);
      check("unstall_q_xnor", q_xnor, 1'b0);
      step();
      all_idle("unstall_drain");

      // Synchronous clear with a full pipe and a simultaneous transfer
      i_bus = 17'h0FFFF; I_VALID = 1'b1; step();
      i_bus = 17'h0FFFE; step();
      check("sclr_pre_ov_and", ov_and, 1'b1);
      i_bus = 17'h0FFFF; SCLR = 1'b1; I_VALID = 1'b1;
      step();
      SCLR = 1'b0; I_VALID = 1'b0;
      all_idle("sclr");
      check("sclr_q_and", q_and, 1'b0);
      for (int k = 0; k < 4; k++) begin
         step();
         all_idle("sclr_after");
      end

      // CE low freezes everything and masks SCLR
      i_bus = 17'h0FFFF; I_VALID = 1'b1; step();
      I_VALID = 1'b0; step();
      CE = 1'b0; SCLR = 1'b1; I_VALID = 1'b1; i_bus = '0; #1;
      check("ce0_ir_and", ir_and, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("ce0_q_and", q_and, 1'b1);
         check("ce0_ov_and", ov_and, 1'b1);
         check("ce0_ov_xnor", ov_xnor, 1'b0);
      end
      CE = 1'b1; SCLR = 1'b0; I_VALID = 1'b0;
      step();
      check("ce1_ov_and", ov_and, 1'b0);
      check("ce1_ov_xnor", ov_xnor, 1'b1);
      check("ce1_q_xnor", q_xnor, 1'b1);
      step();
      all_idle("ce1_drain");

      // Asynchronous reset pulse in mid-cycle with data in flight
      i_bus = 17'h0FFFF; I_VALID = 1'b1; step();
      i_bus = 17'h0FFFE; step();
      I_VALID = 1'b0;
      check("arst_pre_q_and", q_and, 1'b1);
      #3 ACLR_N = 1'b0;
      #1;
      all_idle("arst");
      check("arst_q_and", q_and, 1'b0);
      @(posedge CLK);
      #3 ACLR_N = 1'b1;
      #1;
      check("arst_rel_ir_and", ir_and, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         all_idle("arst_after");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/c_reduce_bus_pipe_v5_0.md
C_REDUCE_BUS_PIPE_V5_0 -- requirements
Module: c_reduce_bus_pipe_v5_0

Interface
REQ-001 The block SHALL have parameter C_WIDTH, default 16, giving the input bus width (legal range 2..64).
REQ-002 The block SHALL have parameter C_GATE_TYPE, default 0, selecting the reduction: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
REQ-003 The block SHALL have parameter C_INPUT_INV_MASK, default all zeros (C_WIDTH bits), where a 1 inverts that input bit before reduction.
REQ-004 The block SHALL have parameter C_GROUP, default 4, giving the fan-in per pipeline stage (legal range 2..8).
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock; all flops are rising-edge.
REQ-006 The block SHALL have port ACLR_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port CE, input, 1 bit: clock enable; while 0, all state holds.
REQ-008 The block SHALL have port SCLR, input, 1 bit: synchronous clear, qualified by CE.
REQ-009 The block SHALL have ports I (input, C_WIDTH bits, operand bus), I_VALID (input, 1) and I_READY (output, 1).
REQ-010 The block SHALL have ports Q (output, 1 bit, registered reduction result), O_VALID (output, 1) and O_READY (input, 1).

Function
REQ-011 STAGES SHALL equal ceil(log_C_GROUP(C_WIDTH)), minimum 1; with the defaults, STAGES = 2.
REQ-012 Each stage SHALL reduce groups of C_GROUP bits from the previous stage using the base operator (AND, OR or XOR). Unused group slots SHALL be padded with the identity value: 1 for AND, 0 for OR and XOR.
REQ-013 For NAND, NOR and XNOR, the final stage SHALL invert the base-operator result; intermediate stages SHALL never invert.
REQ-014 The input inversion mask SHALL be applied before the first stage.
REQ-015 Pipeline advance SHALL be defined as ADV = CE and (not O_VALID or O_READY).
REQ-016 I_READY SHALL equal ADV, combinationally.
REQ-017 A transfer SHALL occur when I_VALID and I_READY are both 1 in the same cycle.
REQ-018 On ADV, every stage register and its valid bit SHALL shift one stage; stage 1 valid SHALL load I_VALID.
REQ-019 Latency from input transfer to O_VALID=1 SHALL be exactly STAGES cycles when no stall occurs.
REQ-020 When O_VALID=1 and O_READY=0, all stages SHALL hold, and Q and O_VALID SHALL be stable.
REQ-021 Throughput SHALL be one result per cycle while O_READY=1 and CE=1.
REQ-022 Bubbles (I_VALID=0) SHALL propagate as valid=0 stages; they are not compressed except at the output stall point.
REQ-023 SCLR=1 with CE=1 SHALL clear all valid bits and Q to 0 at the clock edge, regardless of handshake state.
REQ-024 SCLR SHALL take priority over any transfer in the same cycle; the transferred input is dropped.
REQ-025 With CE=0, SCLR SHALL be ignored.

Reset
REQ-026 Asserting ACLR_N=0 SHALL immediately force Q=0, O_VALID=0 and all internal valid bits to 0, regardless of CLK and CE.
REQ-027 Data registers other than Q are don't-care after reset.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; no result SHALL be emitted after deassertion unless a new input is transferred.
REQ-029 I_READY SHALL be 1 from the first cycle after deassertion when CE=1.

Structure
REQ-030 The gate-type constants (c_and through c_xnor), the identity-value function and the STAGES computation function SHALL live in the shared baseblocks package.
REQ-031 One sub-module, c_reduce_stage_v5_0, SHALL implement a single registered reduction level and be instantiated STAGES times via generate.
REQ-032 No FIFO and no skid buffer SHALL be used; backpressure SHALL be combinational through ADV.

Verification
REQ-033 Scenario: defaults (AND, width 16), I=16'hFFFF, then 16'hFFFE, back-to-back with O_READY=1. Required: Q=1 two cycles after the first transfer, then Q=0 one cycle later, with O_VALID=1 on both.
REQ-034 Scenario: C_GATE_TYPE=5 (XNOR), C_WIDTH=17, I=17'h00001. Required: STAGES=3; Q=0 with O_VALID=1 exactly three cycles after the transfer.
REQ-035 Scenario: C_GATE_TYPE=2 (OR), C_INPUT_INV_MASK=16'hFFFF, I=16'hFFFF. Required: Q=0. With I=16'hFFF7, Q=1.
REQ-036 Scenario: hold O_READY=0 for 5 cycles while the output is valid. Required: I_READY=0, and Q/O_VALID unchanged throughout; on O_READY=1, the next result appears in the following cycle.
REQ-037 Scenario: pipeline full; assert SCLR=1, CE=1 together with I_VALID=1. Required: O_VALID=0 next cycle, and no result is emitted for that input.
REQ-038 Scenario: pulse ACLR_N low mid-cycle while in flight. Required: Q=0 and O_VALID=0 immediately, with no stale result after release.
